// File: rtl/param_arbiter_if.sv
// Request/grant bundle between the bus masters and the N-way arbiter.
interface param_arbiter_if #(
   parameter int N = 4
);
   localparam int IW = $clog2(N);

   logic [N-1:0]  request;
   logic          mode;
   logic [N-1:0]  grant;
   logic          grant_valid;
   logic [IW-1:0] grant_id;

   modport master (
      output request,
      output mode,
      input  grant,
      input  grant_valid,
      input  grant_id
   );

   modport slave (
      input  request,
      input  mode,
      output grant,
      output grant_valid,
      output grant_id
   );
endinterface

// File: rtl/param_arbiter.sv
// N-requester arbiter: fixed-priority or round-robin pick, grant held while the
// owner keeps requesting, tenure bounded by MAX_HOLD under contention.
module param_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic            clk,
   input  logic            rst,
   param_arbiter_if.slave  bus
);
   localparam int IW = $clog2(N);
   localparam int HW = $clog2(MAX_HOLD + 1);

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_GRANTED = 1'b1
   } state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [N-1:0]  grant_q, grant_d;
   logic          valid_q, valid_d;
   logic [IW-1:0] id_q, id_d;

   logic          do_pick_s;
   logic [N-1:0]  pick_vec_s;
   logic [N-1:0]  others_s;
   logic [IW-1:0] winner_s;

   // Fixed mode: highest set index. Round-robin: first set index after ptr.
   function automatic logic [IW-1:0] pick(input logic [N-1:0] vec,
                                          input logic rr,
                                          input logic [IW-1:0] ptr);
      logic [IW-1:0] idx;
      logic [IW-1:0] j;
      logic          found;
      idx   = '0;
      found = 1'b0;
      if (rr) begin
         for (int k = 1; k <= N; k++) begin
            j = IW'((int'(ptr) + k) % N);
            if (vec[j] && !found) begin
               idx   = j;
               found = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (vec[IW'(i)]) begin
               idx = IW'(i);
            end
         end
      end
      return idx;
   endfunction

   assign others_s = bus.request & ~(N'(1) << owner_q);
   assign winner_s = pick(pick_vec_s, bus.mode, ptr_q);

   // Next-state decision: hold, release/hand over, preempt or go idle.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      ptr_d      = ptr_q;
      hcnt_d     = hcnt_q;
      grant_d    = grant_q;
      valid_d    = valid_q;
      id_d       = id_q;
      do_pick_s  = 1'b0;
      pick_vec_s = bus.request;

      case (state_q)
         ST_IDLE: begin
            if (bus.request != {N{1'b0}}) begin
               do_pick_s = 1'b1;
            end else begin
               grant_d = '0;
               valid_d = 1'b0;
               id_d    = '0;
            end
         end
         ST_GRANTED: begin
            if (!bus.request[owner_q]) begin
               if (bus.request != {N{1'b0}}) begin
                  do_pick_s = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  grant_d = '0;
                  valid_d = 1'b0;
                  id_d    = '0;
                  hcnt_d  = '0;
               end
            end else if (hcnt_q < HW'(MAX_HOLD)) begin
               hcnt_d = hcnt_q + HW'(1);
            end else if (others_s != {N{1'b0}}) begin
               do_pick_s  = 1'b1;
               pick_vec_s = others_s;
            end else begin
               hcnt_d = HW'(MAX_HOLD);
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
            valid_d = 1'b0;
            id_d    = '0;
            hcnt_d  = '0;
         end
      endcase

      if (do_pick_s) begin
         state_d           = ST_GRANTED;
         owner_d           = winner_s;
         ptr_d             = winner_s;
         hcnt_d            = HW'(1);
         grant_d           = '0;
         grant_d[winner_s] = 1'b1;
         valid_d           = 1'b1;
         id_d              = winner_s;
      end else begin
         ptr_d = ptr_q;
      end
   end

   // State and registered outputs; reset clears outputs without a clock edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         ptr_q   <= IW'(N - 1);
         hcnt_q  <= '0;
         grant_q <= '0;
         valid_q <= 1'b0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         hcnt_q  <= hcnt_d;
         grant_q <= grant_d;
         valid_q <= valid_d;
         id_q    <= id_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_valid = valid_q;
   assign bus.grant_id    = id_q;

endmodule

// File: tb/tb_param_arbiter.sv
// Directed scenarios for param_arbiter with N=4, MAX_HOLD=2.
module tb_param_arbiter;
   logic clk;
   logic rst;
   int   errors;
   int   checks;

   param_arbiter_if #(.N(4)) bus ();

   param_arbiter #(.N(4), .MAX_HOLD(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      bus.request = 4'b0000;
      #12;
      rst = 1'b1;
      cyc();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.request = 4'b1111;
      bus.mode = 1'b0;
      #23;
      checks++;
      if (bus.grant !== 4'b0000) begin
         errors++;
         $display("FAIL reset_grant: got %b want 0000", bus.grant);
      end
      checks++;
      if (bus.grant_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: got %b want 0", bus.grant_valid);
      end
      checks++;
      if (bus.grant_id !== 2'd0) begin
         errors++;
         $display("FAIL reset_id: got %0d want 0", bus.grant_id);
      end
      bus.request = 4'b0000;
      rst = 1'b1;
      cyc();
   endtask

   task automatic test_fixed();
      bus.mode = 1'b0;
      bus.request = 4'b1010;
      cyc();
      checks++;
      if (bus.grant !== 4'b1000 || bus.grant_id !== 2'd3 || bus.grant_valid !== 1'b1) begin
         errors++;
         $display("FAIL fixed_first: got %b id %0d v %b want 1000 id 3 v 1",
                  bus.grant, bus.grant_id, bus.grant_valid);
      end
      bus.request = 4'b0010;
      cyc();
      checks++;
      if (bus.grant !== 4'b0010 || bus.grant_id !== 2'd1) begin
         errors++;
         $display("FAIL fixed_release: got %b id %0d want 0010 id 1", bus.grant, bus.grant_id);
      end
      bus.request = 4'b0000;
      cyc();
      checks++;
      if (bus.grant !== 4'b0000 || bus.grant_valid !== 1'b0 || bus.grant_id !== 2'd0) begin
         errors++;
         $display("FAIL fixed_idle: got %b v %b id %0d want 0000 v 0 id 0",
                  bus.grant, bus.grant_valid, bus.grant_id);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_tbl [9];
      logic [1:0] exp_id  [9];
      exp_tbl = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                  4'b0100, 4'b1000, 4'b1000, 4'b0001};
      exp_id  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
      do_reset();
      bus.mode = 1'b1;
      bus.request = 4'b1111;
      for (int i = 0; i < 9; i++) begin
         cyc();
         checks++;
         if (bus.grant !== exp_tbl[i] || bus.grant_id !== exp_id[i]) begin
            errors++;
            $display("FAIL rr_step%0d: got %b id %0d want %b id %0d",
                     i, bus.grant, bus.grant_id, exp_tbl[i], exp_id[i]);
         end
      end
      bus.request = 4'b0000;
      cyc();
   endtask

   task automatic test_back_to_back();
      bus.mode = 1'b1;
      bus.request = 4'b0001;
      cyc();
      bus.request = 4'b0101;
      cyc();
      checks++;
      if (bus.grant !== 4'b0001 || bus.grant_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_owner: got %b v %b want 0001 v 1", bus.grant, bus.grant_valid);
      end
      bus.request = 4'b0100;
      cyc();
      checks++;
      if (bus.grant !== 4'b0100 || bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd2) begin
         errors++;
         $display("FAIL b2b_handover: got %b v %b id %0d want 0100 v 1 id 2",
                  bus.grant, bus.grant_valid, bus.grant_id);
      end
      bus.request = 4'b0000;
      cyc();
   endtask

   task automatic test_saturation();
      int bad;
      bad = 0;
      bus.mode = 1'b1;
      bus.request = 4'b0100;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (bus.grant !== 4'b0100) begin
            bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL sat_hold: got %0d cycles off-grant want 0", bad);
      end
      bus.request = 4'b0101;
      cyc();
      checks++;
      if (bus.grant !== 4'b0001 || bus.grant_id !== 2'd0) begin
         errors++;
         $display("FAIL sat_preempt: got %b id %0d want 0001 id 0", bus.grant, bus.grant_id);
      end
      bus.request = 4'b0000;
      cyc();
   endtask

   task automatic test_mode_switch();
      bus.mode = 1'b0;
      bus.request = 4'b1000;
      cyc();
      bus.mode = 1'b1;
      bus.request = 4'b1011;
      cyc();
      checks++;
      if (bus.grant !== 4'b1000) begin
         errors++;
         $display("FAIL mode_keep: got %b want 1000", bus.grant);
      end
      bus.request = 4'b0011;
      cyc();
      checks++;
      if (bus.grant !== 4'b0001 || bus.grant_id !== 2'd0) begin
         errors++;
         $display("FAIL mode_rr_pick: got %b id %0d want 0001 id 0", bus.grant, bus.grant_id);
      end
   endtask

   task automatic test_reset_mid();
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (bus.grant !== 4'b0000 || bus.grant_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: got %b v %b want 0000 v 0", bus.grant, bus.grant_valid);
      end
      bus.request = 4'b0000;
      #2;
      rst = 1'b1;
      cyc();
      checks++;
      if (bus.grant !== 4'b0000) begin
         errors++;
         $display("FAIL rst_idle: got %b want 0000", bus.grant);
      end
      bus.request = 4'b0110;
      cyc();
      checks++;
      if (bus.grant !== 4'b0010 || bus.grant_id !== 2'd1) begin
         errors++;
         $display("FAIL rst_first_pick: got %b id %0d want 0010 id 1", bus.grant, bus.grant_id);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      bus.request = 4'b0000;
      bus.mode = 1'b0;
      test_reset();
      test_fixed();
      test_round_robin();
      test_back_to_back();
      test_saturation();
      test_mode_switch();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
